// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: runs WIDTH-bit AND/NOT/OR/XOR/ADD/SUB/TRANSFER/TEST through one alu1 slice.
// Optional zero flag output res_zero is built when ALU_SERIAL_ZERO_FLAG_EN is defined.
module alu_serial_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_carry_in,
  output logic [2:0]       slice_select,
  input  logic             slice_out,
  input  logic             slice_carry_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  output logic             res_zero,
`endif
  output logic             res_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [2:0]       op_q;
  logic             carry_reg;
  logic             run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      op_q      <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          a_sh      <= req_a;
          b_sh      <= req_b;
          op_q      <= req_op;
          carry_reg <= req_cin;
          cnt       <= '0;
          state     <= S_RUN;
        end
        S_RUN: begin
          // LSB result bit enters at the top and ends up at bit 0 after WIDTH shifts
          res_sh    <= {slice_out, res_sh[WIDTH-1:1]};
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          carry_reg <= slice_carry_out;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) state <= S_DONE;
        end
        S_DONE: if (res_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign run            = (state == S_RUN);
  assign req_ready      = (state == S_IDLE);
  assign res_valid      = (state == S_DONE);
  assign slice_a        = run & a_sh[0];
  assign slice_b        = run & b_sh[0];
  assign slice_carry_in = run & carry_reg;
  // op_q only changes at acceptance, so select holds its last value between ops
  assign slice_select   = op_q;
  assign res_data       = res_valid ? res_sh : '0;
  assign res_cout       = res_valid & carry_reg & ((op_q == OP_ADD) | (op_q == OP_SUB));

`ifdef ALU_SERIAL_ZERO_FLAG_EN
  assign res_zero       = res_valid & (res_sh == '0);
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl (WIDTH=4) with a behavioural alu1 slice and a word-level result model.
module tb_alu_serial_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_cin;
  logic [2:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic         slice_a, slice_b, slice_carry_in, slice_out, slice_carry_out;
  logic [2:0]   slice_select;
  logic         res_valid, res_ready, res_cout;
  logic [W-1:0] res_data;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic         res_zero;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .slice_a(slice_a), .slice_b(slice_b), .slice_carry_in(slice_carry_in),
    .slice_select(slice_select), .slice_out(slice_out), .slice_carry_out(slice_carry_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    .res_zero(res_zero),
`endif
    .res_cout(res_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // one-bit alu1 stand-in; SUB carry_out is the borrow of a-b-cin
  always_comb begin
    slice_out       = 1'b0;
    slice_carry_out = 1'b0;
    case (slice_select)
      3'd0: slice_out = slice_a & slice_b;
      3'd1: slice_out = ~slice_a;
      3'd2: slice_out = slice_a | slice_b;
      3'd3: slice_out = slice_a ^ slice_b;
      3'd4: {slice_carry_out, slice_out} = {1'b0, slice_a} + {1'b0, slice_b} + {1'b0, slice_carry_in};
      3'd5: begin
        slice_out       = slice_a ^ slice_b ^ slice_carry_in;
        slice_carry_out = (~slice_a & slice_b) | (~slice_a & slice_carry_in) | (slice_b & slice_carry_in);
      end
      3'd6: slice_out = slice_a;
      default: slice_out = ~(slice_a ^ slice_b);
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, output logic [W-1:0] d, output logic co);
    logic [W:0] t;
    co = 1'b0;
    t  = '0;
    case (op)
      3'd0: d = a & b;
      3'd1: d = ~a;
      3'd2: d = a | b;
      3'd3: d = a ^ b;
      3'd4: begin t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin}; d = t[W-1:0]; co = t[W]; end
      3'd5: begin t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin}; d = t[W-1:0]; co = t[W]; end
      3'd6: d = a;
      default: d = ~(a ^ b);
    endcase
  endfunction

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, d;
    logic         co;
    int           acc;
  } exp_t;
  exp_t q[$];

  // cycle-by-cycle compare against the queue of accepted operations
  always @(negedge clk) begin
    exp_t e;
    int k;
    if (!rst_n) begin
      q.delete();
      chk("rst req_ready", req_ready, 1);
      chk("rst res_valid", res_valid, 0);
      chk("rst res_data", res_data, 0);
      chk("rst res_cout", res_cout, 0);
      chk("rst slice_sel", slice_select, 0);
      chk("rst slice_a", slice_a, 0);
    end else begin
      if (q.size() == 0) begin
        chk("idle req_ready", req_ready, 1);
        chk("idle res_valid", res_valid, 0);
        chk("idle slice_a", slice_a, 0);
        chk("idle slice_b", slice_b, 0);
        chk("idle slice_cin", slice_carry_in, 0);
      end else begin
        k = cyc - q[0].acc;
        chk("busy req_ready", req_ready, 0);
        chk("busy slice_sel", slice_select, q[0].op);
        if (k < W) begin
          chk("run res_valid", res_valid, 0);
          chk("run slice_a", slice_a, q[0].a[k]);
          chk("run slice_b", slice_b, q[0].b[k]);
        end else begin
          chk("done res_valid", res_valid, 1);
          chk("done res_data", res_data, q[0].d);
          chk("done res_cout", res_cout, q[0].co);
          chk("done slice_cin", slice_carry_in, 0);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
          chk("done res_zero", res_zero, (q[0].d == '0));
`endif
          if (res_ready) void'(q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        e.op = req_op; e.a = req_a; e.b = req_b; e.acc = cyc + 1;
        model(req_op, req_a, req_b, req_cin, e.d, e.co);
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int n;
    @(posedge clk); #1;
    req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    if (n >= 50) chk("accept timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = ~a; req_b = ~b; req_op = ~op; req_cin = ~cin;
  endtask

  task automatic wait_res(input logic [W-1:0] ed, input logic ec);
    int k;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!res_valid && k < 50);
    chk("latency", k, W);
    chk("vec res_data", res_data, ed);
    chk("vec res_cout", res_cout, ec);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    chk("vec res_zero", res_zero, (ed == '0));
`endif
  endtask

  task automatic run_vec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [W-1:0] ed, input logic ec);
    logic [W-1:0] md;
    logic mc;
    model(op, a, b, cin, md, mc);
    chk("model data", md, ed);
    chk("model cout", mc, ec);
    send(op, a, b, cin);
    wait_res(ed, ec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_cin = 1'b0;
    res_ready = 1'b1;
    #12;
    chk("por req_ready", req_ready, 1);
    chk("por res_valid", res_valid, 0);
    chk("por res_data", res_data, 0);
    #10 rst_n = 1'b1;

    run_vec(3'd4, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0);
    run_vec(3'd4, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1);
    run_vec(3'd5, 4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1);
    run_vec(3'd5, 4'b0101, 4'b0011, 1'b1, 4'b0001, 1'b0);
    run_vec(3'd1, 4'b0101, 4'b0000, 1'b0, 4'b1010, 1'b0);
    run_vec(3'd7, 4'b1010, 4'b1010, 1'b0, 4'b1111, 1'b0);
    run_vec(3'd3, 4'b1100, 4'b1010, 1'b0, 4'b0110, 1'b0);
    run_vec(3'd0, 4'b1100, 4'b1010, 1'b1, 4'b1000, 1'b0);
    run_vec(3'd2, 4'b1100, 4'b1010, 1'b0, 4'b1110, 1'b0);
    run_vec(3'd6, 4'b1001, 4'b0110, 1'b1, 4'b1001, 1'b0);
    run_vec(3'd4, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);
    run_vec(3'd5, 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1);

    // back-pressure with a request waiting behind the result
    send(3'd4, 4'b0011, 4'b0001, 1'b0);
    res_ready = 1'b0;
    wait_res(4'b0100, 1'b0);
    req_op = 3'd3; req_a = 4'b1100; req_b = 4'b1010; req_cin = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp res_valid", res_valid, 1);
      chk("bp res_data", res_data, 4'b0100);
      chk("bp req_ready", req_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("gap req_ready", req_ready, 1);
    chk("gap res_valid", res_valid, 0);
    @(posedge clk); #1;
    chk("pend accepted", req_ready, 0);
    req_valid = 1'b0;
    wait_res(4'b0110, 1'b0);

    // asynchronous reset during RUN bit 2
    send(3'd4, 4'b0111, 4'b0001, 1'b0);
    @(posedge clk); @(posedge clk); #3;
    chk("pre-rst slice_a", slice_a, 1);
    rst_n = 1'b0;
    #1;
    chk("arst req_ready", req_ready, 1);
    chk("arst res_valid", res_valid, 0);
    chk("arst res_data", res_data, 0);
    chk("arst res_cout", res_cout, 0);
    chk("arst slice_a", slice_a, 0);
    chk("arst slice_cin", slice_carry_in, 0);
    chk("arst slice_sel", slice_select, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    run_vec(3'd4, 4'b0010, 4'b0010, 1'b0, 4'b0100, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
